// File: rtl/dram_oq_pkg.sv
// ---------------------------------------------------------------------------
// dram_oq_pkg
//   Shared definitions for the DRAM output-queue block: default widths,
//   arbiter state encoding (one-hot) and the DRAM operation encoding.
// ---------------------------------------------------------------------------
package dram_oq_pkg;

   localparam int DRAM_ADDR_W     = 22;  // default DRAM word-address width
   localparam int DRAM_BLK_ADDR_W = 3;   // default ring block-index width

   typedef enum logic [4:0] {
      ST_IDLE    = 5'b00001,
      ST_WR_REQ  = 5'b00010,
      ST_WR_XFER = 5'b00100,
      ST_RD_REQ  = 5'b01000,
      ST_RD_XFER = 5'b10000
   } arb_state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } dram_op_e;

endpackage

// File: rtl/dram_block_counter.sv
// ---------------------------------------------------------------------------
// dram_block_counter
//   Up/down occupancy counter for the block ring, with registered full and
//   empty flags that always match the registered count.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   inc_i          one block was stored
//   dec_i          one block was removed
//   block_num_i    ring size in blocks
//   count_o        occupied blocks
//   full_o         count_o >= block_num_i (also covers a shrunken ring)
//   empty_o        count_o == 0
// ---------------------------------------------------------------------------
module dram_block_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic [CNT_W-1:0] block_num_i,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full_q, empty_q;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i) begin
         cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Flags are derived from the next count so they change on the same edge
   // as the count itself; block_num changes show up one cycle later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d >= block_num_i);
         empty_q <= (cnt_d == '0);
      end
   end

   assign count_o = cnt_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/dram_rw_arbiter.sv
// ---------------------------------------------------------------------------
// dram_rw_arbiter
//   Shares one DRAM controller port between the block writer and the block
//   reader of a DRAM output queue. One whole-block transfer at a time; the
//   grant is held until that transfer completes or times out.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   wr_req/wr_urgent/wr_ptr writer request, FIFO-almost-full, block address
//   wr_grant/wr_done        1-cycle pulses: write starts / write finished
//   rd_req/rd_ptr           reader request, block address
//   rd_grant/rd_done        1-cycle pulses: read starts / read finished
//   dram_req/we/addr        request to controller (we: 1=write, 0=read)
//   dram_ack/dram_done      controller accepted / finished
//   block_num               ring size in blocks
//   blocks_used             occupied-block count
//   ring_full/ring_empty    occupancy flags
//   timeout_err             sticky abort indication
// ---------------------------------------------------------------------------
module dram_rw_arbiter
   import dram_oq_pkg::*;
#(
   parameter int DRAM_ADDR_WIDTH       = DRAM_ADDR_W,
   parameter int DRAM_BLOCK_ADDR_WIDTH = DRAM_BLK_ADDR_W,
   parameter int MAX_CONSEC_WR         = 4,
   parameter int TIMEOUT_CYCLES        = 1024
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           wr_req,
   input  logic                           wr_urgent,
   input  logic [DRAM_ADDR_WIDTH-1:0]     wr_ptr,
   output logic                           wr_grant,
   output logic                           wr_done,
   input  logic                           rd_req,
   input  logic [DRAM_ADDR_WIDTH-1:0]     rd_ptr,
   output logic                           rd_grant,
   output logic                           rd_done,
   output logic                           dram_req,
   output logic                           dram_we,
   output logic [DRAM_ADDR_WIDTH-1:0]     dram_addr,
   input  logic                           dram_ack,
   input  logic                           dram_done,
   input  logic [DRAM_BLOCK_ADDR_WIDTH:0] block_num,
   output logic [DRAM_BLOCK_ADDR_WIDTH:0] blocks_used,
   output logic                           ring_full,
   output logic                           ring_empty,
   output logic                           timeout_err
);

   localparam int CNT_W = DRAM_BLOCK_ADDR_WIDTH + 1;
   localparam int STK_W = $clog2(MAX_CONSEC_WR + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_e                 state_q, state_d;
   logic [STK_W-1:0]           streak_q, streak_d;
   logic [TMR_W-1:0]           timer_q, timer_d;
   logic                       wr_grant_q, wr_grant_d;
   logic                       rd_grant_q, rd_grant_d;
   logic                       wr_done_q, wr_done_d;
   logic                       rd_done_q, rd_done_d;
   logic                       dram_we_q, dram_we_d;
   logic [DRAM_ADDR_WIDTH-1:0] dram_addr_q, dram_addr_d;
   logic                       timeout_err_q, timeout_err_d;

   logic cnt_inc, cnt_dec;
   logic full_w, empty_w;
   logic wr_ok, rd_ok, streak_room, timeout_hit;

   dram_block_counter #(
      .CNT_W (CNT_W)
   ) u_block_counter (
      .clk         (clk),
      .reset_n     (reset_n),
      .inc_i       (cnt_inc),
      .dec_i       (cnt_dec),
      .block_num_i (block_num),
      .count_o     (blocks_used),
      .full_o      (full_w),
      .empty_o     (empty_w)
   );

   always_comb begin
      wr_ok         = wr_req && !full_w;
      rd_ok         = rd_req && !empty_w;
      streak_room   = (streak_q < STK_W'(MAX_CONSEC_WR));
      // timer_q counts busy cycles already spent, so the last allowed one
      // is TIMEOUT_CYCLES-1.
      timeout_hit   = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

      state_d       = state_q;
      streak_d      = streak_q;
      timer_d       = timer_q;
      wr_grant_d    = 1'b0;
      rd_grant_d    = 1'b0;
      wr_done_d     = 1'b0;
      rd_done_d     = 1'b0;
      dram_we_d     = dram_we_q;
      dram_addr_d   = dram_addr_q;
      timeout_err_d = timeout_err_q;
      cnt_inc       = 1'b0;
      cnt_dec       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (!rd_req) begin
               streak_d = '0;
            end
            if (wr_ok && (!rd_ok || wr_urgent || streak_room)) begin
               state_d     = ST_WR_REQ;
               wr_grant_d  = 1'b1;
               dram_we_d   = OP_WR;
               dram_addr_d = wr_ptr;
               // Only writes that overtake a waiting read count against it.
               if (rd_ok && streak_room) begin
                  streak_d = streak_q + 1'b1;
               end
            end else if (rd_ok) begin
               state_d     = ST_RD_REQ;
               rd_grant_d  = 1'b1;
               dram_we_d   = OP_RD;
               dram_addr_d = rd_ptr;
               streak_d    = '0;
            end
         end
         ST_WR_REQ, ST_RD_REQ: begin
            timer_d = timer_q + 1'b1;
            if (timeout_hit) begin
               state_d       = ST_IDLE;
               timeout_err_d = 1'b1;
            end else if (dram_ack) begin
               state_d = (state_q == ST_WR_REQ) ? ST_WR_XFER : ST_RD_XFER;
            end
         end
         ST_WR_XFER, ST_RD_XFER: begin
            timer_d = timer_q + 1'b1;
            if (timeout_hit) begin
               state_d       = ST_IDLE;
               timeout_err_d = 1'b1;
            end else if (dram_done) begin
               state_d = ST_IDLE;
               if (state_q == ST_WR_XFER) begin
                  wr_done_d = 1'b1;
                  cnt_inc   = 1'b1;
               end else begin
                  rd_done_d = 1'b1;
                  cnt_dec   = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         streak_q      <= '0;
         timer_q       <= '0;
         wr_grant_q    <= 1'b0;
         rd_grant_q    <= 1'b0;
         wr_done_q     <= 1'b0;
         rd_done_q     <= 1'b0;
         dram_we_q     <= 1'b0;
         dram_addr_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         streak_q      <= streak_d;
         timer_q       <= timer_d;
         wr_grant_q    <= wr_grant_d;
         rd_grant_q    <= rd_grant_d;
         wr_done_q     <= wr_done_d;
         rd_done_q     <= rd_done_d;
         dram_we_q     <= dram_we_d;
         dram_addr_q   <= dram_addr_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign wr_grant    = wr_grant_q;
   assign rd_grant    = rd_grant_q;
   assign wr_done     = wr_done_q;
   assign rd_done     = rd_done_q;
   assign dram_req    = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
   assign dram_we     = dram_we_q;
   assign dram_addr   = dram_addr_q;
   assign ring_full   = full_w;
   assign ring_empty  = empty_w;
   assign timeout_err = timeout_err_q;

endmodule
